// File: rtl/mult_pkg.sv
// Shared definitions for the iterative 16x16 shift-add multiplier.
//   mult_state_t : controller states
//   MULT_WIDTH   : operand width (tied to the shared adder width)
//   MULT_CNT_W   : iteration counter width, log2(MULT_WIDTH)
//   mag16()      : unsigned magnitude of a two's-complement operand
package mult_pkg;

  localparam int unsigned MULT_WIDTH = 16;
  localparam int unsigned MULT_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    NEG_LO,
    NEG_HI,
    DONE
  } mult_state_t;

  // 0x8000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [MULT_WIDTH-1:0] mag16(input logic [MULT_WIDTH-1:0] x);
    return x[MULT_WIDTH-1] ? (~x + 16'd1) : x;
  endfunction

endpackage

// File: rtl/mult_fsm.sv
// Controller for the iterative multiplier: state register, iteration
// counter, busy/done decode and the adder-port select lines.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start       : request, honoured only in IDLE
//   neg         : result must be negated after the shift-add phase
//   busy, done  : status (done is a one-cycle pulse in DONE)
//   load        : operands are being latched this cycle
//   sel_calc    : shift-add step active
//   sel_neg_lo  : negate low half
//   sel_neg_hi  : negate high half using the stored carry
module mult_fsm
  import mult_pkg::*;
#(
  parameter int unsigned CNT_W = MULT_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic neg,
  output logic busy,
  output logic done,
  output logic load,
  output logic sel_calc,
  output logic sel_neg_lo,
  output logic sel_neg_hi
);

  mult_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load       = 1'b0;
    sel_calc   = 1'b0;
    sel_neg_lo = 1'b0;
    sel_neg_hi = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        sel_calc = 1'b1;
        // Counter wraps to zero on the last iteration.
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = neg ? NEG_LO : DONE;
      end
      NEG_LO: begin
        sel_neg_lo = 1'b1;
        state_d    = NEG_HI;
      end
      NEG_HI: begin
        sel_neg_hi = 1'b1;
        state_d    = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/seq_mult_div_free_multiplier.sv
// 16x16 -> 32-bit iterative shift-add multiplier (MIPS mult/multu into
// HI/LO). All accumulate and negate steps use the parent's shared adder.
//   clk, rst_n         : clock, asynchronous active-low reset
//   start, is_signed   : request and signedness, latched in IDLE
//   op_a, op_b         : multiplicand / multiplier
//   busy, done         : status; done pulses when the product is valid
//   prod_hi, prod_lo   : HI / LO result registers
//   add_a/add_b/add_cin: operands driven to the shared adder
//   add_sum/add_cout   : result returned from the shared adder
module seq_mult_div_free_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH,
  parameter int unsigned CNT_W = MULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout
);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] prod_hi_q, prod_hi_d;
  logic [WIDTH-1:0] prod_lo_q, prod_lo_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic             load, sel_calc, sel_neg_lo, sel_neg_hi;

  mult_fsm #(
    .CNT_W(CNT_W)
  ) u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .neg        (neg_q),
    .busy       (busy),
    .done       (done),
    .load       (load),
    .sel_calc   (sel_calc),
    .sel_neg_lo (sel_neg_lo),
    .sel_neg_hi (sel_neg_hi)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
      neg_q     <= 1'b0;
      carry_q   <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      prod_hi_q <= prod_hi_d;
      prod_lo_q <= prod_lo_d;
      neg_q     <= neg_d;
      carry_q   <= carry_d;
    end
  end

  always_comb begin
    mcand_d   = mcand_q;
    prod_hi_d = prod_hi_q;
    prod_lo_d = prod_lo_q;
    neg_d     = neg_q;
    carry_d   = carry_q;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    if (load) begin
      mcand_d   = is_signed ? mag16(op_a) : op_a;
      prod_lo_d = is_signed ? mag16(op_b) : op_b;
      prod_hi_d = '0;
      neg_d     = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
    end else if (sel_calc) begin
      add_a = prod_hi_q;
      add_b = prod_lo_q[0] ? mcand_q : '0;
      // {cout, sum, lo} shifted right by one; lo's LSB is consumed.
      prod_hi_d = {add_cout, add_sum[WIDTH-1:1]};
      prod_lo_d = {add_sum[0], prod_lo_q[WIDTH-1:1]};
    end else if (sel_neg_lo) begin
      add_a     = ~prod_lo_q;
      add_cin   = 1'b1;
      prod_lo_d = add_sum;
      carry_d   = add_cout;
    end else if (sel_neg_hi) begin
      add_a     = ~prod_hi_q;
      add_cin   = carry_q;
      prod_hi_d = add_sum;
    end
  end

  assign prod_hi = prod_hi_q;
  assign prod_lo = prod_lo_q;

endmodule

// File: tb/tb_seq_mult_div_free_multiplier.sv
// Directed self-checking bench for seq_mult_div_free_multiplier, with a
// behavioural 16-bit adder standing in for the parent's shared CLA.
module tb_seq_mult_div_free_multiplier;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic        busy, done;
  logic [15:0] prod_hi, prod_lo;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic [16:0] sum_full;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  assign sum_full = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};
  assign add_sum  = sum_full[15:0];
  assign add_cout = sum_full[16];

  seq_mult_div_free_multiplier #(
    .WIDTH(16),
    .CNT_W(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .prod_hi   (prod_hi),
    .prod_lo   (prod_lo),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one operation; reports cycles from start edge to done (-1 on
  // timeout), the product seen with done, then the status and product one
  // cycle later. With poke set, start is re-asserted with different
  // operands during CALC and again in the DONE cycle.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input bit poke, output int lat, output logic [31:0] p_done,
                        output logic busy_after, output logic [31:0] p_after);
    @(negedge clk);
    op_a = a; op_b = b; is_signed = s; start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    lat    = -1;
    p_done = '0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (poke && k == 5) begin
        start = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555; is_signed = ~s;
      end
      if (poke && k == 6) start = 1'b0;
      if (done) begin
        lat    = k;
        p_done = {prod_hi, prod_lo};
        break;
      end
    end
    if (poke) begin
      start = 1'b1; op_a = 16'h0101; op_b = 16'h0202; is_signed = 1'b0;
    end
    @(posedge clk); #1;
    start      = 1'b0;
    busy_after = busy;
    p_after    = {prod_hi, prod_lo};
  endtask

  int          lat;
  logic [31:0] p_done, p_after;
  logic        b_after;
  bit          done_seen;

  initial begin
    // Reset state
    #12;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_prod", {prod_hi, prod_lo}, 32'd0);
    check_eq("rst_adder", {add_a, add_b}, 32'd0);
    check_eq("rst_cin", {31'd0, add_cin}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // multu 3 x 5
    run_op(16'd3, 16'd5, 1'b0, 1'b0, lat, p_done, b_after, p_after);
    check_eq("u3x5_lat", lat, 32'd17);
    check_eq("u3x5_prod", p_done, 32'h0000_000F);
    check_eq("u3x5_busy_after", {31'd0, b_after}, 32'd0);

    // multu FFFF x FFFF
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, lat, p_done, b_after, p_after);
    check_eq("uffff_lat", lat, 32'd17);
    check_eq("uffff_prod", p_done, 32'hFFFE_0001);

    // mult -3 x 5
    run_op(16'hFFFD, 16'h0005, 1'b1, 1'b0, lat, p_done, b_after, p_after);
    check_eq("sm3x5_lat", lat, 32'd19);
    check_eq("sm3x5_prod", p_done, 32'hFFFF_FFF1);
    check_eq("sm3x5_idle_adder", {add_a, add_b}, 32'd0);

    // mult 0x8000 x 0x8000
    run_op(16'h8000, 16'h8000, 1'b1, 1'b0, lat, p_done, b_after, p_after);
    check_eq("s8000_lat", lat, 32'd17);
    check_eq("s8000_prod", p_done, 32'h4000_0000);

    // mult -1 x 0: negative sign, zero product
    run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, lat, p_done, b_after, p_after);
    check_eq("sm1x0_lat", lat, 32'd19);
    check_eq("sm1x0_prod", p_done, 32'd0);

    // multu 0x1234 x 0x0010 with start poked mid-op and in DONE
    run_op(16'h1234, 16'h0010, 1'b0, 1'b1, lat, p_done, b_after, p_after);
    check_eq("poke_lat", lat, 32'd17);
    check_eq("poke_prod", p_done, 32'h0001_2340);
    check_eq("poke_busy_after", {31'd0, b_after}, 32'd0);
    check_eq("poke_prod_hold", p_after, 32'h0001_2340);

    // Reset mid-operation at cycle 8
    @(negedge clk);
    op_a = 16'h1234; op_b = 16'h5678; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", {31'd0, busy}, 32'd0);
    check_eq("midrst_prod", {prod_hi, prod_lo}, 32'd0);
    done_seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) begin @(negedge clk); rst_n = 1'b1; end
      @(posedge clk); #1;
      if (done) done_seen = 1'b1;
    end
    check_eq("midrst_no_done", {31'd0, done_seen}, 32'd0);

    run_op(16'd2, 16'd7, 1'b0, 1'b0, lat, p_done, b_after, p_after);
    check_eq("u2x7_lat", lat, 32'd17);
    check_eq("u2x7_prod", p_done, 32'h0000_000E);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
